vga_disp_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares the single VGA digit display path among NREQ requesters (CPU output ports / register taps).
- Grants one requester at a time and captures its 8-bit value.
- Converts the value to three decimal digits with a sequential double-dabble over 8 cycles.
- Holds the result on screen for a minimum of HOLD_CYCLES before the next grant. Sits between the CPU datapath and the VGA character generator.

---
 rtl/vga_disp_arb_pkg.sv | 21 ++
 rtl/vga_disp_arb_if.sv | 31 +++
 rtl/vga_disp_arb_bcd_dabble.sv | 59 +++++
 rtl/vga_disp_arb.sv | 148 ++++++++++++++
 tb/tb_vga_disp_arb.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_disp_arb_pkg.sv
// Shared types and constants for the VGA display arbiter.
package vga_disp_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StHold
    } state_e;

    localparam int unsigned BCD_W      = 12;
    localparam int unsigned CONV_STEPS = 8;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned VAL_W      = 8;
    localparam int unsigned SRC_W      = 3;

    // Double-dabble correction: a nibble that would reach >=10 after the shift is pre-biased.
    function automatic logic [DIGIT_W-1:0] dabble_adjust(input logic [DIGIT_W-1:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/vga_disp_arb_if.sv
// Requester/display bundle between the CPU-side requesters and the display arbiter.
interface vga_disp_arb_if
    import vga_disp_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4
) ();

    logic                    vgae;
    logic [NREQ-1:0]         req;
    logic [VAL_W*NREQ-1:0]   data;
    logic [NREQ-1:0]         gnt;
    logic [SRC_W-1:0]        src;
    logic [DIGIT_W-1:0]      d2;
    logic [DIGIT_W-1:0]      d1;
    logic [DIGIT_W-1:0]      d0;
    logic                    valid;
    logic                    busy;

    // Requester / display side.
    modport master (
        output vgae, req, data,
        input  gnt, src, d2, d1, d0, valid, busy
    );

    // Arbiter side.
    modport slave (
        input  vgae, req, data,
        output gnt, src, d2, d1, d0, valid, busy
    );

endinterface

// File: rtl/vga_disp_arb_bcd_dabble.sv
// Sequential 8-bit binary to three-digit BCD converter, one shift-add step per clock.
module vga_disp_arb_bcd_dabble
    import vga_disp_arb_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [VAL_W-1:0]   bin,
    output logic               done,
    output logic [DIGIT_W-1:0] d2,
    output logic [DIGIT_W-1:0] d1,
    output logic [DIGIT_W-1:0] d0
);

    localparam int unsigned STEP_W = $clog2(CONV_STEPS);

    logic [VAL_W-1:0]       bin_q;
    logic [BCD_W-1:0]       bcd_q;
    logic [STEP_W-1:0]      step_q;
    logic                   run_q;
    logic [BCD_W-1:0]       adj;
    logic [BCD_W+VAL_W-1:0] shifted;

    // One iteration: correct every nibble, then shift the combined bcd/bin word left.
    always_comb begin
        adj     = {dabble_adjust(bcd_q[11:8]), dabble_adjust(bcd_q[7:4]),
                   dabble_adjust(bcd_q[3:0])};
        shifted = {adj, bin_q} << 1;
        // done marks the cycle whose closing edge performs the final step; the digits
        // presented here are the post-step values the caller latches on that edge.
        done    = run_q && (step_q == STEP_W'(CONV_STEPS - 1));
        d2      = shifted[VAL_W+8 +: DIGIT_W];
        d1      = shifted[VAL_W+4 +: DIGIT_W];
        d0      = shifted[VAL_W   +: DIGIT_W];
    end

    // Conversion state: load on start, step while running, stop after the last step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            step_q <= '0;
            run_q  <= 1'b0;
        end else if (start) begin
            bin_q  <= bin;
            bcd_q  <= '0;
            step_q <= '0;
            run_q  <= 1'b1;
        end else if (run_q) begin
            bin_q  <= shifted[VAL_W-1:0];
            bcd_q  <= shifted[BCD_W+VAL_W-1:VAL_W];
            step_q <= step_q + 1'b1;
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/vga_disp_arb.sv
// Round-robin arbiter sharing the VGA digit display among NREQ requesters.
module vga_disp_arb
    import vga_disp_arb_pkg::*;
#(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input logic           clk,
    input logic           reset,
    vga_disp_arb_if.slave bus
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned DATA_W = VAL_W * NREQ;

    state_e             state_q, state_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic [SRC_W-1:0]   pend_q, pend_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic [SRC_W-1:0]   pick;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [NREQ-1:0]    req_rot;
    logic [DATA_W-1:0]  data_rot;
    logic [VAL_W-1:0]   cap_val;
    logic               found;
    logic               start;
    logic               conv_done;
    logic [DIGIT_W-1:0] dig2, dig1, dig0;
    logic [DIGIT_W-1:0] d2_q, d2_d, d1_q, d1_d, d0_q, d0_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;

    // Rotate requests so ptr sits at bit 0, then take the lowest set bit.
    always_comb begin
        req_rot  = NREQ'({bus.req, bus.req} >> ptr_q);
        data_rot = DATA_W'({bus.data, bus.data} >> {ptr_q, 3'b000});
        found    = 1'b0;
        pick     = '0;
        cap_val  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && req_rot[k]) begin
                found   = 1'b1;
                pick    = SRC_W'((32'(ptr_q) + k) % NREQ);
                cap_val = data_rot[VAL_W*k +: VAL_W];
            end
        end
        start = (state_q == StIdle) && bus.vgae && found;
    end

    vga_disp_arb_bcd_dabble u_dabble (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (cap_val),
        .done  (conv_done),
        .d2    (dig2),
        .d1    (dig1),
        .d0    (dig0)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: grant -> convert for 8 edges -> hold -> back to arbitration.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StConv;
            StConv:  if (conv_done) state_d = StHold;
            StHold:  if (hold_q == '0) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs, pointer and hold timer.
    always_comb begin
        gnt_d   = '0;
        ptr_d   = ptr_q;
        pend_d  = pend_q;
        src_d   = src_q;
        d2_d    = d2_q;
        d1_d    = d1_q;
        d0_d    = d0_q;
        valid_d = valid_q;
        hold_d  = hold_q;
        if (start) begin
            gnt_d  = {{(NREQ-1){1'b0}}, 1'b1} << pick;
            ptr_d  = (32'(pick) == NREQ - 1) ? '0 : pick + 1'b1;
            pend_d = pick;
        end
        // Digits and src move together on the completion edge only, never mid-conversion.
        if (state_q == StConv && conv_done) begin
            d2_d    = dig2;
            d1_d    = dig1;
            d0_d    = dig0;
            src_d   = pend_q;
            valid_d = 1'b1;
            hold_d  = HOLD_W'(HOLD_CYCLES - 1);
        end
        if (state_q == StHold && hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end
        busy_d = (state_d != StIdle);
    end

    // Output and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q   <= '0;
            ptr_q   <= '0;
            pend_q  <= '0;
            src_q   <= '0;
            d2_q    <= '0;
            d1_q    <= '0;
            d0_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
            src_q   <= src_d;
            d2_q    <= d2_d;
            d1_q    <= d1_d;
            d0_q    <= d0_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.src   = src_q;
    assign bus.d2    = d2_q;
    assign bus.d1    = d1_q;
    assign bus.d0    = d0_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_vga_disp_arb.sv
// Scoreboard bench for vga_disp_arb: edge-level reference model feeds queues, monitor compares.
module tb_vga_disp_arb;

    localparam int unsigned NREQ = 4;
    localparam int unsigned HOLD = 16;
    localparam int unsigned GAP  = 9 + HOLD;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    vga_disp_arb_if #(.NREQ(NREQ)) bus ();

    vga_disp_arb #(
        .NREQ        (NREQ),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned at;
        int unsigned idx;
        int unsigned val;
    } ev_t;

    ev_t gq[$];
    ev_t dq[$];

    int unsigned edge_cnt = 0;
    int unsigned ok_edge  = 0;
    int unsigned busy_end = 0;
    int unsigned mptr     = 0;
    int          checks   = 0;
    int          passes   = 0;

    logic [NREQ-1:0] rr_pend   = '0;
    bit              auto_rr   = 1'b0;
    bit              rand_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d, t=%0t)",
                     name, act, exp, edge_cnt, $time);
        end
    endtask

    // Reference model: a grant happens on any edge where the display is free, vgae is high
    // and someone requests; winner is the first requester at or after the rotating pointer.
    initial begin
        forever begin
            @(posedge clk);
            edge_cnt++;
            if (reset) begin
                gq.delete();
                dq.delete();
                mptr     = 0;
                ok_edge  = 0;
                busy_end = 0;
            end else if (edge_cnt >= ok_edge && bus.vgae && (bus.req != '0)) begin
                int unsigned w;
                ev_t e;
                w = NREQ;
                for (int k = 0; k < int'(NREQ); k++) begin
                    int unsigned j;
                    j = (mptr + k) % NREQ;
                    if (w == NREQ && bus.req[j]) w = j;
                end
                e.at  = edge_cnt;
                e.idx = w;
                e.val = int'(bus.data[8*w +: 8]);
                gq.push_back(e);
                e.at  = edge_cnt + 8;
                dq.push_back(e);
                ok_edge  = edge_cnt + GAP;
                busy_end = edge_cnt + 8 + HOLD;
                mptr     = (w + 1) % NREQ;
            end
        end
    end

    // Monitor: compares DUT outputs each falling edge against the scoreboard.
    logic [3:0] e2 = '0, e1 = '0, e0 = '0;
    logic [2:0] esrc = '0;
    logic       evld = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                gq.delete();
                dq.delete();
                busy_end = 0;
                e2 = '0; e1 = '0; e0 = '0; esrc = '0; evld = 1'b0;
                chk("reset_outputs",
                    32'({bus.gnt, bus.src, bus.d2, bus.d1, bus.d0, bus.valid, bus.busy}), 32'd0);
            end else begin
                if (bus.gnt != '0) begin
                    if (gq.size() == 0) begin
                        chk("gnt_unexpected", 32'(bus.gnt), 32'd0);
                    end else begin
                        ev_t g;
                        g = gq.pop_front();
                        chk("gnt_edge", edge_cnt, g.at);
                        chk("gnt_value", 32'(bus.gnt), 32'(1) << g.idx);
                    end
                end else if (gq.size() != 0 && gq[0].at <= edge_cnt) begin
                    ev_t g;
                    g = gq.pop_front();
                    chk("gnt_missing", 32'(bus.gnt), 32'(1) << g.idx);
                end
                if (dq.size() != 0 && dq[0].at <= edge_cnt) begin
                    ev_t d;
                    d = dq.pop_front();
                    e2   = 4'(d.val / 100);
                    e1   = 4'((d.val / 10) % 10);
                    e0   = 4'(d.val % 10);
                    esrc = 3'(d.idx);
                    evld = 1'b1;
                end
                chk("display", 32'({bus.valid, bus.src, bus.d2, bus.d1, bus.d0}),
                    32'({evld, esrc, e2, e1, e0}));
                chk("busy", 32'(bus.busy), 32'(edge_cnt < busy_end));
            end
        end
    end

    // Advance one clock; requesters drop on grant and optionally re-request.
    task automatic tick();
        @(posedge clk);
        #2;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (rr_pend[i]) begin
                bus.req[i] = 1'b1;
                rr_pend[i] = 1'b0;
            end
            if (rand_mode && !bus.req[i] && $urandom_range(0, 99) < 5) begin
                bus.data[8*i +: 8] = 8'($urandom);
                bus.req[i] = 1'b1;
            end
            if (bus.gnt[i]) begin
                bus.req[i] = 1'b0;
                rr_pend[i] = auto_rr;
            end
        end
    endtask

    int n;
    int unsigned vals[4] = '{255, 0, 9, 100};

    initial begin
        bus.vgae = 1'b0;
        bus.req  = '0;
        bus.data = '0;
        #1 reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();

        // Single request: 137 from requester 2.
        bus.data[23:16] = 8'd137;
        bus.vgae = 1'b1;
        bus.req  = 4'b0100;
        repeat (GAP + 4) tick();

        // Boundary values through requester 3; leaves the pointer back at 0.
        foreach (vals[v]) begin
            bus.data[31:24] = 8'(vals[v]);
            bus.req[3] = 1'b1;
            repeat (GAP + 2) tick();
        end

        // All requesting, each re-requests right after its grant.
        for (int i = 0; i < int'(NREQ); i++) bus.data[8*i +: 8] = 8'($urandom);
        auto_rr = 1'b1;
        bus.req = 4'b1111;
        repeat (4 * GAP + 3) tick();
        auto_rr = 1'b0;
        bus.req = '0;
        repeat (GAP + 2) tick();

        // Display disabled: no arbitration until vgae returns.
        bus.vgae = 1'b0;
        bus.req  = 4'b0010;
        repeat (50) tick();
        bus.vgae = 1'b1;
        repeat (GAP + 4) tick();

        // Reset in the 4th conversion cycle, then the pointer must restart at 0.
        bus.req = 4'b1110;
        n = 0;
        while (bus.gnt == '0 && n < 60) begin
            tick();
            n++;
        end
        chk("wait_gnt_timeout", 32'(n < 60), 32'd1);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        tick();
        bus.req = 4'b1111;
        reset   = 1'b0;
        n = 0;
        while (bus.gnt == '0 && n < 10) begin
            tick();
            n++;
        end
        chk("post_reset_gnt", 32'(bus.gnt), 32'd1);
        repeat (GAP + 4) tick();
        bus.req = '0;
        repeat (GAP + 2) tick();

        // Randomised traffic with occasional vgae toggling.
        rand_mode = 1'b1;
        repeat (3000) begin
            if ($urandom_range(0, 99) == 0) bus.vgae = ~bus.vgae;
            tick();
        end
        rand_mode = 1'b0;
        bus.req   = '0;
        bus.vgae  = 1'b1;
        repeat (GAP + 10) tick();

        chk("scoreboard_drained", 32'(gq.size() + dq.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
